prog_sequencer: RTL

//  Run-control and program-counter sequencer for the 8-bit encryption core.
//  - Owns the PC that addresses instruction ROM.
//  - Consumes the decoder's per-instruction BranchEn and Ack (halt) strobes.
//  - Provides the Start/Done handshake to the testbench or host.
//  - Sits between the instruction decoder and instruction memory.
//  - Clk is the only clock; Reset is synchronous and active-high.

---
 rtl/seq_pkg.sv | 12 +
 rtl/sat_counter.sv | 19 +
 rtl/prog_sequencer.sv | 81 ++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the program sequencer and instruction decoder.
package seq_pkg;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_RUN  = 2'd1,
        SEQ_DONE = 2'd2
    } seq_state_t;

    localparam logic [7:0] HALT_OPCODE = 8'h00;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over enable.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + {{(W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/prog_sequencer.sv
// Run-control and PC sequencer for the 8-bit encryption core.
// Optional RUN-cycle counter enabled by defining SEQ_CYCLE_COUNT_EN.
module prog_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned          PC_W       = 10,
    parameter logic [PC_W-1:0]      START_ADDR = '0,
    parameter int unsigned          CNT_W      = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Halt,
    input  logic             BranchEn,
    input  logic [PC_W-1:0]  BranchTarget,
    input  logic             Stall,
    output logic [PC_W-1:0]  PC,
    output logic             Running,
    output logic             Done,
    output logic [CNT_W-1:0] CycleCount
);

    seq_state_t      state;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_inc;

    assign pc_inc = pc_q + {{(PC_W-1){1'b0}}, 1'b1};

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= SEQ_IDLE;
            pc_q  <= START_ADDR;
        end else begin
            case (state)
                SEQ_IDLE, SEQ_DONE: begin
                    if (Start) begin
                        state <= SEQ_RUN;
                        pc_q  <= START_ADDR;
                    end
                end
                SEQ_RUN: begin
                    // Stall freezes everything; otherwise Halt outranks BranchEn.
                    if (!Stall) begin
                        if (Halt) begin
                            state <= SEQ_DONE;
                        end else if (BranchEn) begin
                            pc_q <= BranchTarget;
                        end else begin
                            pc_q <= pc_inc;
                        end
                    end
                end
                default: begin
                    state <= SEQ_IDLE;
                    pc_q  <= START_ADDR;
                end
            endcase
        end
    end

    assign PC      = pc_q;
    assign Running = (state == SEQ_RUN);
    assign Done    = (state == SEQ_DONE);

`ifdef SEQ_CYCLE_COUNT_EN
    logic start_accept;
    assign start_accept = Start && (state != SEQ_RUN);

    sat_counter #(
        .W (CNT_W)
    ) u_cycle_cnt (
        .clk    (Clk),
        .clear  (Reset || start_accept),
        .enable (state == SEQ_RUN),
        .count  (CycleCount)
    );
`else
    assign CycleCount = '0;
`endif

endmodule
